// File: rtl/frog_game_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | frog_game_ctrl_if : frog position / vehicle rows in, game state out          |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface frog_game_ctrl_if #(
  parameter int DATAWIDTH_BUS      = 8,
  parameter int DATAWIDTH_SELECTOR = 3
);
  logic                          FROGCTRL_START;
  logic [DATAWIDTH_SELECTOR-1:0] FROGCTRL_PX_IN;
  logic [DATAWIDTH_SELECTOR-1:0] FROGCTRL_PY_IN;
  logic [DATAWIDTH_BUS-1:0]      FROGCTRL_VEH7_IN;
  logic [DATAWIDTH_BUS-1:0]      FROGCTRL_VEH6_IN;
  logic [DATAWIDTH_BUS-1:0]      FROGCTRL_VEH5_IN;
  logic [DATAWIDTH_BUS-1:0]      FROGCTRL_VEH4_IN;
  logic [DATAWIDTH_BUS-1:0]      FROGCTRL_VEH3_IN;
  logic [DATAWIDTH_BUS-1:0]      FROGCTRL_VEH2_IN;
  logic [DATAWIDTH_BUS-1:0]      FROGCTRL_VEH1_IN;
  logic                          FROGCTRL_INI_OUT;
  logic                          FROGCTRL_HIT_OUT;
  logic [2:0]                    FROGCTRL_LIVES_OUT;
  logic [3:0]                    FROGCTRL_SCORE_OUT;
  logic [2:0]                    FROGCTRL_STATE_OUT;

  modport master (
    output FROGCTRL_START, FROGCTRL_PX_IN, FROGCTRL_PY_IN,
           FROGCTRL_VEH7_IN, FROGCTRL_VEH6_IN, FROGCTRL_VEH5_IN, FROGCTRL_VEH4_IN,
           FROGCTRL_VEH3_IN, FROGCTRL_VEH2_IN, FROGCTRL_VEH1_IN,
    input  FROGCTRL_INI_OUT, FROGCTRL_HIT_OUT, FROGCTRL_LIVES_OUT,
           FROGCTRL_SCORE_OUT, FROGCTRL_STATE_OUT
  );

  modport slave (
    input  FROGCTRL_START, FROGCTRL_PX_IN, FROGCTRL_PY_IN,
           FROGCTRL_VEH7_IN, FROGCTRL_VEH6_IN, FROGCTRL_VEH5_IN, FROGCTRL_VEH4_IN,
           FROGCTRL_VEH3_IN, FROGCTRL_VEH2_IN, FROGCTRL_VEH1_IN,
    output FROGCTRL_INI_OUT, FROGCTRL_HIT_OUT, FROGCTRL_LIVES_OUT,
           FROGCTRL_SCORE_OUT, FROGCTRL_STATE_OUT
  );
endinterface
`default_nettype wire

// File: rtl/frog_game_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | frog_game_ctrl : collision/goal detection, lives, score and respawn control |
// | Optional macro FROGCTRL_GRACE_EN adds post-respawn collision immunity.       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module frog_game_ctrl #(
  parameter int DATAWIDTH_BUS      = 8,
  parameter int DATAWIDTH_SELECTOR = 3,
  parameter int LIVES_INIT         = 3,
  parameter int GOAL_ROW           = 7,
  parameter int HOLD_CYCLES        = 16
`ifdef FROGCTRL_GRACE_EN
  ,
  parameter int GRACE_CYCLES       = 32
`endif
) (
  input  wire logic        FROGCTRL_CLOCK_50,
  input  wire logic        FROGCTRL_RESET,
  frog_game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  localparam logic [2:0]                    c_lives_init = 3'(LIVES_INIT);
  localparam logic [7:0]                    c_hold_load  = 8'(HOLD_CYCLES - 1);
  localparam logic [DATAWIDTH_SELECTOR-1:0] c_goal_row   = DATAWIDTH_SELECTOR'(GOAL_ROW);

  state_t                   state_q;
  logic                     ini_q;
  logic                     hit_q;
  logic [2:0]               lives_q;
  logic [3:0]               score_q;
  logic [7:0]               timer_q;
  logic [DATAWIDTH_BUS-1:0] row_sel;
  logic                     coll;
  logic                     coll_eff;
  logic                     goal;
  logic                     respawn;

  // Row 0 is the safe starting lane and never carries vehicles.
  always_comb begin
    row_sel = '0;
    case (bus.FROGCTRL_PY_IN)
      3'd1:    row_sel = bus.FROGCTRL_VEH1_IN;
      3'd2:    row_sel = bus.FROGCTRL_VEH2_IN;
      3'd3:    row_sel = bus.FROGCTRL_VEH3_IN;
      3'd4:    row_sel = bus.FROGCTRL_VEH4_IN;
      3'd5:    row_sel = bus.FROGCTRL_VEH5_IN;
      3'd6:    row_sel = bus.FROGCTRL_VEH6_IN;
      3'd7:    row_sel = bus.FROGCTRL_VEH7_IN;
      default: row_sel = '0;
    endcase
  end

  assign coll = row_sel[bus.FROGCTRL_PX_IN];
  assign goal = (bus.FROGCTRL_PY_IN == c_goal_row);

  // Every INI pulse (start, restart, respawn) comes from this one term.
  assign respawn = (((state_q == S_IDLE) || (state_q == S_OVER)) && bus.FROGCTRL_START) ||
                   ((state_q == S_WIN) && (timer_q == 8'd0)) ||
                   ((state_q == S_HIT) && (timer_q == 8'd0) && (lives_q != 3'd0));

`ifdef FROGCTRL_GRACE_EN
  logic [7:0] grace_q;

  always_ff @(posedge FROGCTRL_CLOCK_50 or negedge FROGCTRL_RESET) begin
    if (!FROGCTRL_RESET) begin
      grace_q <= 8'd0;
    end else if (respawn) begin
      grace_q <= 8'(GRACE_CYCLES);
    end else if ((state_q == S_PLAY) && (grace_q != 8'd0)) begin
      grace_q <= grace_q - 8'd1;
    end
  end

  assign coll_eff = coll && (grace_q == 8'd0);
`else
  assign coll_eff = coll;
`endif

  always_ff @(posedge FROGCTRL_CLOCK_50 or negedge FROGCTRL_RESET) begin
    if (!FROGCTRL_RESET) begin
      state_q <= S_IDLE;
      ini_q   <= 1'b1;
      hit_q   <= 1'b0;
      lives_q <= 3'd0;
      score_q <= 4'd0;
      timer_q <= 8'd0;
    end else begin
      ini_q <= respawn;
      hit_q <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (bus.FROGCTRL_START) begin
            state_q <= S_PLAY;
            lives_q <= c_lives_init;
            score_q <= 4'd0;
          end
        end
        S_PLAY: begin
          if (coll_eff) begin
            state_q <= S_HIT;
            hit_q   <= 1'b1;
            timer_q <= c_hold_load;
            if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
          end else if (goal) begin
            state_q <= S_WIN;
            timer_q <= c_hold_load;
            if (score_q != 4'd15) score_q <= score_q + 4'd1;
          end
        end
        S_HIT: begin
          if (timer_q == 8'd0) state_q <= (lives_q == 3'd0) ? S_OVER : S_PLAY;
          else                 timer_q <= timer_q - 8'd1;
        end
        S_WIN: begin
          if (timer_q == 8'd0) state_q <= S_PLAY;
          else                 timer_q <= timer_q - 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.FROGCTRL_INI_OUT   = ini_q;
  assign bus.FROGCTRL_HIT_OUT   = hit_q;
  assign bus.FROGCTRL_LIVES_OUT = lives_q;
  assign bus.FROGCTRL_SCORE_OUT = score_q;
  assign bus.FROGCTRL_STATE_OUT = state_q;

endmodule
`default_nettype wire

// File: tb/tb_frog_game_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_frog_game_ctrl : directed self-checking bench for frog_game_ctrl          |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_frog_game_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  frog_game_ctrl_if #(.DATAWIDTH_BUS(8), .DATAWIDTH_SELECTOR(3)) bus ();

  frog_game_ctrl dut (
    .FROGCTRL_CLOCK_50 (clk),
    .FROGCTRL_RESET    (rst_n),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.FROGCTRL_PX_IN   = 3'd0;
    bus.FROGCTRL_PY_IN   = 3'd0;
    bus.FROGCTRL_VEH7_IN = 8'h00;
    bus.FROGCTRL_VEH6_IN = 8'h00;
    bus.FROGCTRL_VEH5_IN = 8'h00;
    bus.FROGCTRL_VEH4_IN = 8'h00;
    bus.FROGCTRL_VEH3_IN = 8'h00;
    bus.FROGCTRL_VEH2_IN = 8'h00;
    bus.FROGCTRL_VEH1_IN = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.FROGCTRL_START = 1'b0;
    clear_inputs();
    repeat (3) tick();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d exp 0", bus.FROGCTRL_STATE_OUT); end
    checks++; if (bus.FROGCTRL_INI_OUT !== 1'b1) begin failures++; $display("FAIL reset_ini: got %b exp 1", bus.FROGCTRL_INI_OUT); end
    checks++; if (bus.FROGCTRL_HIT_OUT !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b exp 0", bus.FROGCTRL_HIT_OUT); end
    checks++; if (bus.FROGCTRL_LIVES_OUT !== 3'd0) begin failures++; $display("FAIL reset_lives: got %0d exp 0", bus.FROGCTRL_LIVES_OUT); end
    checks++; if (bus.FROGCTRL_SCORE_OUT !== 4'd0) begin failures++; $display("FAIL reset_score: got %0d exp 0", bus.FROGCTRL_SCORE_OUT); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd0 || bus.FROGCTRL_INI_OUT !== 1'b0) begin failures++; $display("FAIL idle_after_reset: state=%0d ini=%b exp state=0 ini=0", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_INI_OUT); end
  endtask

  task automatic test_start();
    bus.FROGCTRL_START = 1'b1;
    tick();
    bus.FROGCTRL_START = 1'b0;
    checks++; if (bus.FROGCTRL_INI_OUT !== 1'b1) begin failures++; $display("FAIL start_ini: got %b exp 1", bus.FROGCTRL_INI_OUT); end
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd1) begin failures++; $display("FAIL start_state: got %0d exp 1", bus.FROGCTRL_STATE_OUT); end
    checks++; if (bus.FROGCTRL_LIVES_OUT !== 3'd3) begin failures++; $display("FAIL start_lives: got %0d exp 3", bus.FROGCTRL_LIVES_OUT); end
    checks++; if (bus.FROGCTRL_SCORE_OUT !== 4'd0) begin failures++; $display("FAIL start_score: got %0d exp 0", bus.FROGCTRL_SCORE_OUT); end
    tick();
    checks++; if (bus.FROGCTRL_INI_OUT !== 1'b0 || bus.FROGCTRL_STATE_OUT !== 3'd1) begin failures++; $display("FAIL start_ini_pulse: ini=%b state=%0d exp ini=0 state=1", bus.FROGCTRL_INI_OUT, bus.FROGCTRL_STATE_OUT); end
  endtask

  task automatic test_collision();
    bit bad = 0;
    bus.FROGCTRL_PY_IN   = 3'd3;
    bus.FROGCTRL_PX_IN   = 3'd5;
    bus.FROGCTRL_VEH3_IN = 8'b0010_0000;
    tick();
    checks++; if (bus.FROGCTRL_HIT_OUT !== 1'b1) begin failures++; $display("FAIL coll_hit: got %b exp 1", bus.FROGCTRL_HIT_OUT); end
    checks++; if (bus.FROGCTRL_LIVES_OUT !== 3'd2) begin failures++; $display("FAIL coll_lives: got %0d exp 2", bus.FROGCTRL_LIVES_OUT); end
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd2) begin failures++; $display("FAIL coll_state: got %0d exp 2", bus.FROGCTRL_STATE_OUT); end
    // Collision stays asserted through the hold: must not decrement again.
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.FROGCTRL_STATE_OUT !== 3'd2 || bus.FROGCTRL_HIT_OUT !== 1'b0 || bus.FROGCTRL_INI_OUT !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL coll_hold: state=%0d hit=%b exp state=2 hit=0 for 15 cycles", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_HIT_OUT); end
    clear_inputs();
    tick();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd1 || bus.FROGCTRL_INI_OUT !== 1'b1) begin failures++; $display("FAIL coll_respawn: state=%0d ini=%b exp state=1 ini=1", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_INI_OUT); end
    checks++; if (bus.FROGCTRL_LIVES_OUT !== 3'd2) begin failures++; $display("FAIL coll_single_dec: got %0d exp 2", bus.FROGCTRL_LIVES_OUT); end
    tick();
    checks++; if (bus.FROGCTRL_INI_OUT !== 1'b0) begin failures++; $display("FAIL coll_ini_pulse: got %b exp 0", bus.FROGCTRL_INI_OUT); end
  endtask

  task automatic test_goal();
    bit bad = 0;
    bus.FROGCTRL_PY_IN = 3'd7;
    bus.FROGCTRL_PX_IN = 3'd2;
    tick();
    bus.FROGCTRL_PY_IN = 3'd0;
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd3 || bus.FROGCTRL_SCORE_OUT !== 4'd1) begin failures++; $display("FAIL goal_win: state=%0d score=%0d exp state=3 score=1", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_SCORE_OUT); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.FROGCTRL_STATE_OUT !== 3'd3) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL goal_hold: state=%0d exp 3 for 15 cycles", bus.FROGCTRL_STATE_OUT); end
    tick();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd1 || bus.FROGCTRL_INI_OUT !== 1'b1 || bus.FROGCTRL_LIVES_OUT !== 3'd2) begin failures++; $display("FAIL goal_respawn: state=%0d ini=%b lives=%0d exp 1 1 2", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_INI_OUT, bus.FROGCTRL_LIVES_OUT); end
  endtask

  task automatic test_coll_priority();
    bus.FROGCTRL_PY_IN   = 3'd7;
    bus.FROGCTRL_PX_IN   = 3'd4;
    bus.FROGCTRL_VEH7_IN = 8'h10;
    tick();
    clear_inputs();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd2 || bus.FROGCTRL_HIT_OUT !== 1'b1) begin failures++; $display("FAIL prio_hit: state=%0d hit=%b exp state=2 hit=1", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_HIT_OUT); end
    checks++; if (bus.FROGCTRL_SCORE_OUT !== 4'd1 || bus.FROGCTRL_LIVES_OUT !== 3'd1) begin failures++; $display("FAIL prio_counts: score=%0d lives=%0d exp score=1 lives=1", bus.FROGCTRL_SCORE_OUT, bus.FROGCTRL_LIVES_OUT); end
    repeat (16) tick();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd1 || bus.FROGCTRL_INI_OUT !== 1'b1) begin failures++; $display("FAIL prio_respawn: state=%0d ini=%b exp 1 1", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_INI_OUT); end
  endtask

  task automatic test_game_over();
    bit bad = 0;
    bus.FROGCTRL_PY_IN   = 3'd5;
    bus.FROGCTRL_PX_IN   = 3'd7;
    bus.FROGCTRL_VEH5_IN = 8'h80;
    tick();
    clear_inputs();
    checks++; if (bus.FROGCTRL_HIT_OUT !== 1'b1 || bus.FROGCTRL_LIVES_OUT !== 3'd0) begin failures++; $display("FAIL last_hit: hit=%b lives=%0d exp hit=1 lives=0", bus.FROGCTRL_HIT_OUT, bus.FROGCTRL_LIVES_OUT); end
    repeat (16) tick();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd4 || bus.FROGCTRL_INI_OUT !== 1'b0) begin failures++; $display("FAIL over_entry: state=%0d ini=%b exp state=4 ini=0", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_INI_OUT); end
    bus.FROGCTRL_PY_IN   = 3'd7;
    bus.FROGCTRL_VEH7_IN = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.FROGCTRL_STATE_OUT !== 3'd4 || bus.FROGCTRL_LIVES_OUT !== 3'd0 || bus.FROGCTRL_SCORE_OUT !== 4'd1 || bus.FROGCTRL_HIT_OUT !== 1'b0) bad = 1;
    end
    clear_inputs();
    checks++; if (bad) begin failures++; $display("FAIL over_hold: state=%0d lives=%0d score=%0d exp 4 0 1", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_LIVES_OUT, bus.FROGCTRL_SCORE_OUT); end
    bus.FROGCTRL_START = 1'b1;
    tick();
    bus.FROGCTRL_START = 1'b0;
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd1 || bus.FROGCTRL_INI_OUT !== 1'b1) begin failures++; $display("FAIL restart_state: state=%0d ini=%b exp 1 1", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_INI_OUT); end
    checks++; if (bus.FROGCTRL_LIVES_OUT !== 3'd3 || bus.FROGCTRL_SCORE_OUT !== 4'd0) begin failures++; $display("FAIL restart_counts: lives=%0d score=%0d exp 3 0", bus.FROGCTRL_LIVES_OUT, bus.FROGCTRL_SCORE_OUT); end
  endtask

  task automatic test_score_saturation();
    for (int i = 0; i < 16; i++) begin
      bus.FROGCTRL_PY_IN = 3'd7;
      bus.FROGCTRL_PX_IN = 3'(i % 8);
      tick();
      bus.FROGCTRL_PY_IN = 3'd0;
      checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd3 || bus.FROGCTRL_SCORE_OUT !== 4'((i + 1 > 15) ? 15 : i + 1)) begin failures++; $display("FAIL score_goal%0d: state=%0d score=%0d exp state=3 score=%0d", i, bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_SCORE_OUT, (i + 1 > 15) ? 15 : i + 1); end
      repeat (16) tick();
    end
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd1 || bus.FROGCTRL_SCORE_OUT !== 4'd15 || bus.FROGCTRL_LIVES_OUT !== 3'd3) begin failures++; $display("FAIL score_sat: state=%0d score=%0d lives=%0d exp 1 15 3", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_SCORE_OUT, bus.FROGCTRL_LIVES_OUT); end
  endtask

  task automatic test_row0_safe();
    bit bad = 0;
    bus.FROGCTRL_PY_IN   = 3'd0;
    bus.FROGCTRL_VEH7_IN = 8'hFF; bus.FROGCTRL_VEH6_IN = 8'hFF; bus.FROGCTRL_VEH5_IN = 8'hFF;
    bus.FROGCTRL_VEH4_IN = 8'hFF; bus.FROGCTRL_VEH3_IN = 8'hFF; bus.FROGCTRL_VEH2_IN = 8'hFF;
    bus.FROGCTRL_VEH1_IN = 8'hFF;
    for (int x = 0; x < 8; x++) begin
      bus.FROGCTRL_PX_IN = 3'(x);
      tick();
      if (bus.FROGCTRL_HIT_OUT !== 1'b0 || bus.FROGCTRL_STATE_OUT !== 3'd1) bad = 1;
    end
    clear_inputs();
    checks++; if (bad) begin failures++; $display("FAIL row0_safe: hit=%b state=%0d exp hit=0 state=1", bus.FROGCTRL_HIT_OUT, bus.FROGCTRL_STATE_OUT); end
  endtask

  task automatic test_respawn_collision();
    bit bad = 0;
    bus.FROGCTRL_PY_IN = 3'd7;
    tick();
    bus.FROGCTRL_PY_IN = 3'd0;
    repeat (15) tick();
    bus.FROGCTRL_PY_IN   = 3'd2;
    bus.FROGCTRL_PX_IN   = 3'd1;
    bus.FROGCTRL_VEH2_IN = 8'h02;
    tick();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd1 || bus.FROGCTRL_INI_OUT !== 1'b1) begin failures++; $display("FAIL win_respawn: state=%0d ini=%b exp 1 1", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_INI_OUT); end
`ifdef FROGCTRL_GRACE_EN
    for (int i = 0; i < 32; i++) begin
      tick();
      if (bus.FROGCTRL_HIT_OUT !== 1'b0 || bus.FROGCTRL_STATE_OUT !== 3'd1) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL grace_mask: hit=%b state=%0d exp hit=0 state=1 for 32 cycles", bus.FROGCTRL_HIT_OUT, bus.FROGCTRL_STATE_OUT); end
`endif
    tick();
    checks++; if (bad || bus.FROGCTRL_HIT_OUT !== 1'b1 || bus.FROGCTRL_STATE_OUT !== 3'd2 || bus.FROGCTRL_LIVES_OUT !== 3'd2) begin failures++; $display("FAIL respawn_coll: hit=%b state=%0d lives=%0d exp 1 2 2", bus.FROGCTRL_HIT_OUT, bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_LIVES_OUT); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_hold();
    repeat (5) tick();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd2) begin failures++; $display("FAIL mid_hold_state: got %0d exp 2", bus.FROGCTRL_STATE_OUT); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd0 || bus.FROGCTRL_INI_OUT !== 1'b1 || bus.FROGCTRL_HIT_OUT !== 1'b0) begin failures++; $display("FAIL async_reset_ctrl: state=%0d ini=%b hit=%b exp 0 1 0", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_INI_OUT, bus.FROGCTRL_HIT_OUT); end
    checks++; if (bus.FROGCTRL_LIVES_OUT !== 3'd0 || bus.FROGCTRL_SCORE_OUT !== 4'd0) begin failures++; $display("FAIL async_reset_counts: lives=%0d score=%0d exp 0 0", bus.FROGCTRL_LIVES_OUT, bus.FROGCTRL_SCORE_OUT); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.FROGCTRL_STATE_OUT !== 3'd0 || bus.FROGCTRL_INI_OUT !== 1'b0) begin failures++; $display("FAIL post_reset_idle: state=%0d ini=%b exp 0 0", bus.FROGCTRL_STATE_OUT, bus.FROGCTRL_INI_OUT); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_collision();
    test_goal();
    test_coll_priority();
    test_game_over();
    test_score_saturation();
    test_row0_safe();
    test_respawn_collision();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
